// File: rtl/aes_pkg.sv
// Shared definitions for aes_core: FSM states, key-size codes, Nr/Nk lookup,
// Rcon table and GF(2^8) / S-box helpers (polynomial 0x11B).
// The inverse S-box is only compiled when AES_DEC_EN is defined.
package aes_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StRounds
    } aes_state_e;

    localparam logic [1:0] KeySize128 = 2'd0;
    localparam logic [1:0] KeySize192 = 2'd1;
    localparam logic [1:0] KeySize256 = 2'd2;

    // Number of rounds; code 3 falls back to AES-128.
    function automatic logic [3:0] aes_nr(input logic [1:0] size);
        case (size)
            KeySize128: return 4'd10;
            KeySize192: return 4'd12;
            KeySize256: return 4'd14;
            default:    return 4'd10;
        endcase
    endfunction

    // Key length in 32-bit words.
    function automatic logic [3:0] aes_nk(input logic [1:0] size);
        case (size)
            KeySize128: return 4'd4;
            KeySize192: return 4'd6;
            KeySize256: return 4'd8;
            default:    return 4'd4;
        endcase
    endfunction

    function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] aes_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] aes_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = aes_xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0).
    function automatic logic [7:0] aes_gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a12, a15, a240;
        a2   = aes_gmul(a, a);
        a3   = aes_gmul(a2, a);
        a12  = aes_gmul(aes_gmul(a3, a3), aes_gmul(a3, a3));
        a15  = aes_gmul(a12, a3);
        a240 = aes_gmul(a15, a15);
        a240 = aes_gmul(a240, a240);
        a240 = aes_gmul(a240, a240);
        a240 = aes_gmul(a240, a240);
        return aes_gmul(aes_gmul(a240, a12), a2);
    endfunction

    function automatic logic [7:0] aes_rotl8(input logic [7:0] x, input int unsigned n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] a);
        logic [7:0] x;
        x = aes_gf_inv(a);
        return x ^ aes_rotl8(x, 1) ^ aes_rotl8(x, 2) ^ aes_rotl8(x, 3) ^ aes_rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] aes_sub_word(input logic [31:0] w);
        return {aes_sbox(w[31:24]), aes_sbox(w[23:16]), aes_sbox(w[15:8]), aes_sbox(w[7:0])};
    endfunction

`ifdef AES_DEC_EN
    // Undo the affine transform, then invert in the field.
    function automatic logic [7:0] aes_inv_sbox(input logic [7:0] s);
        return aes_gf_inv(aes_rotl8(s, 1) ^ aes_rotl8(s, 3) ^ aes_rotl8(s, 6) ^ 8'h05);
    endfunction
`endif

endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES round (rounds 1..Nr; the initial key add is done by the
// caller). Byte b of the state sits at bits [127-8b -: 8], column-major (b = row + 4*col).
// With AES_DEC_EN defined, dec_i selects the straight inverse round.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         dec_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {aes_xtime(a0) ^ aes_xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ aes_xtime(a1) ^ aes_xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ aes_xtime(a2) ^ aes_xtime(a3) ^ a3,
                aes_xtime(a0) ^ a0 ^ a1 ^ a2 ^ aes_xtime(a3)};
    endfunction

    logic [127:0] enc_sr;
    logic [127:0] enc_mc;
    logic [127:0] enc_out;

    // Forward round: SubBytes + ShiftRows, MixColumns unless last, then AddRoundKey.
    always_comb begin
        enc_sr  = '0;
        enc_mc  = '0;
        enc_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                enc_sr[127 - 8*(r + 4*c) -: 8] =
                    aes_sbox(state_i[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            enc_mc[127 - 32*c -: 32] = mix_column(enc_sr[127 - 32*c -: 32]);
        end
        enc_out = (last_i ? enc_sr : enc_mc) ^ rkey_i;
    end

`ifdef AES_DEC_EN
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {aes_gmul(a0, 8'h0e) ^ aes_gmul(a1, 8'h0b) ^ aes_gmul(a2, 8'h0d) ^ aes_gmul(a3, 8'h09),
                aes_gmul(a0, 8'h09) ^ aes_gmul(a1, 8'h0e) ^ aes_gmul(a2, 8'h0b) ^ aes_gmul(a3, 8'h0d),
                aes_gmul(a0, 8'h0d) ^ aes_gmul(a1, 8'h09) ^ aes_gmul(a2, 8'h0e) ^ aes_gmul(a3, 8'h0b),
                aes_gmul(a0, 8'h0b) ^ aes_gmul(a1, 8'h0d) ^ aes_gmul(a2, 8'h09) ^ aes_gmul(a3, 8'h0e)};
    endfunction

    logic [127:0] dec_isb;
    logic [127:0] dec_ark;
    logic [127:0] dec_out;

    // Inverse round: InvShiftRows + InvSubBytes, AddRoundKey, InvMixColumns unless last.
    always_comb begin
        dec_isb = '0;
        dec_ark = '0;
        dec_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                dec_isb[127 - 8*(r + 4*c) -: 8] =
                    aes_inv_sbox(state_i[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
            end
        end
        dec_ark = dec_isb ^ rkey_i;
        dec_out = dec_ark;
        if (!last_i) begin
            for (int c = 0; c < 4; c++) begin
                dec_out[127 - 32*c -: 32] = inv_mix_column(dec_ark[127 - 32*c -: 32]);
            end
        end
    end

    assign state_o = dec_i ? dec_out : enc_out;
`else
    logic unused_dec;
    assign unused_dec = dec_i;
    assign state_o    = enc_out;
`endif

endmodule

// File: rtl/aes_core.sv
// aes_core: iterative AES-128/192/256 core. A load expands the key one word per cycle into a
// 60-word store, then runs one round per cycle. Decryption exists only with AES_DEC_EN defined;
// otherwise dec_i is ignored and every operation encrypts, with identical latency.
module aes_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [255:0] key_i,
    input  logic [127:0] data_i,
    input  logic [1:0]   size_i,
    input  logic         dec_i,
    output logic [127:0] data_o,
    output logic         busy_o
);

    aes_state_e   state_q, state_d;
    logic         busy_q, busy_d;
    logic [127:0] dout_q, dout_d;
    logic [127:0] blk_q, blk_d;
    logic [1:0]   size_q, size_d;
    logic         dec_q, dec_d;
    logic [5:0]   idx_q, idx_d;        // next key word to generate
    logic [2:0]   kcnt_q, kcnt_d;      // idx mod Nk
    logic [3:0]   rcon_idx_q, rcon_idx_d;
    logic [3:0]   round_q, round_d;
    logic [31:0]  rk_q [60];

    logic [3:0]   nr;
    logic [3:0]   nk;
    logic [3:0]   key_round;
    logic [5:0]   idx_last;
    logic [5:0]   rk_base;
    logic [31:0]  w_prev;
    logic [31:0]  w_back;
    logic [31:0]  w_tmp;
    logic [31:0]  w_new;
    logic [127:0] round_key;
    logic [127:0] round_out;
    logic         last_round;

`ifndef AES_DEC_EN
    logic unused_dec;
    assign unused_dec = dec_i;
`endif

    assign nr         = aes_nr(size_q);
    assign nk         = aes_nk(size_q);
    assign idx_last   = {nr, 2'b11};
    assign last_round = (state_q == StRounds) && (round_q == nr);
    // Decryption walks the schedule backwards.
    assign key_round  = dec_q ? (nr - round_q) : round_q;
    assign rk_base    = {key_round, 2'b00};
    assign round_key  = {rk_q[rk_base], rk_q[rk_base + 6'd1],
                         rk_q[rk_base + 6'd2], rk_q[rk_base + 6'd3]};

    // Key schedule: next word from w[i-1] and w[i-Nk].
    always_comb begin
        w_prev = rk_q[idx_q - 6'd1];
        w_back = rk_q[idx_q - {2'b00, nk}];
        w_tmp  = w_prev;
        if (kcnt_q == 3'd0) begin
            w_tmp = aes_sub_word({w_prev[23:0], w_prev[31:24]}) ^ {aes_rcon(rcon_idx_q), 24'h0};
        end else if ((nk == 4'd8) && (kcnt_q == 3'd4)) begin
            w_tmp = aes_sub_word(w_prev);
        end
        w_new = w_back ^ w_tmp;
    end

    aes_round u_round (
        .state_i (blk_q),
        .rkey_i  (round_key),
        .dec_i   (dec_q),
        .last_i  (last_round),
        .state_o (round_out)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        dout_d     = dout_q;
        blk_d      = blk_q;
        size_d     = size_q;
        dec_d      = dec_q;
        idx_d      = idx_q;
        kcnt_d     = kcnt_q;
        rcon_idx_d = rcon_idx_q;
        round_d    = round_q;
        case (state_q)
            StIdle: begin
                if (load_i) begin
                    state_d    = StExpand;
                    busy_d     = 1'b1;
                    blk_d      = data_i;
                    size_d     = size_i;
`ifdef AES_DEC_EN
                    dec_d      = dec_i;
`else
                    dec_d      = 1'b0;
`endif
                    idx_d      = {2'b00, aes_nk(size_i)};
                    kcnt_d     = 3'd0;
                    rcon_idx_d = 4'd1;
                end
            end
            StExpand: begin
                idx_d  = idx_q + 6'd1;
                kcnt_d = (kcnt_q == 3'(nk - 4'd1)) ? 3'd0 : kcnt_q + 3'd1;
                if (kcnt_q == 3'd0) rcon_idx_d = rcon_idx_q + 4'd1;
                if (idx_q == idx_last) begin
                    state_d = StRounds;
                    round_d = 4'd0;
                end
            end
            StRounds: begin
                blk_d   = (round_q == 4'd0) ? (blk_q ^ round_key) : round_out;
                round_d = round_q + 4'd1;
                if (last_round) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    dout_d  = round_out;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and datapath registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            dout_q     <= '0;
            blk_q      <= '0;
            size_q     <= '0;
            dec_q      <= 1'b0;
            idx_q      <= '0;
            kcnt_q     <= '0;
            rcon_idx_q <= '0;
            round_q    <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            dout_q     <= dout_d;
            blk_q      <= blk_d;
            size_q     <= size_d;
            dec_q      <= dec_d;
            idx_q      <= idx_d;
            kcnt_q     <= kcnt_d;
            rcon_idx_q <= rcon_idx_d;
            round_q    <= round_d;
        end
    end

    // Round-key store: raw key words on load, then one expanded word per cycle.
    always_ff @(posedge clk) begin
        if ((state_q == StIdle) && load_i) begin
            for (int j = 0; j < 8; j++) begin
                rk_q[j] <= key_i[255 - 32*j -: 32];
            end
        end else if (state_q == StExpand) begin
            rk_q[idx_q] <= w_new;
        end
    end

    assign data_o = dout_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_aes_core.sv
// Bench for aes_core: known FIPS-197 vectors, busy timing, ignored loads, mid-operation reset
// and randomized operations against a byte-level reference cipher built from the FIPS rules.
module tb_aes_core;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         load_i;
    logic [255:0] key_i;
    logic [127:0] data_i;
    logic [1:0]   size_i;
    logic         dec_i;
    logic [127:0] data_o;
    logic         busy_o;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] sb [256];

    always #5 clk = ~clk;

    aes_core dut (
        .clk    (clk),
        .rst_ni (rst_ni),
        .load_i (load_i),
        .key_i  (key_i),
        .data_i (data_i),
        .size_i (size_i),
        .dec_i  (dec_i),
        .data_o (data_o),
        .busy_o (busy_o)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Carry-less product then reduction modulo 0x11B.
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    // S-box by brute-force inverse search and the bitwise affine definition.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] cst;
        logic [7:0] s;
        cst = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (m_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                     ^ inv[(i + 7) % 8] ^ cst[i];
            end
            sb[a] = s;
        end
    endtask

    function automatic logic [31:0] m_subword(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] m_encrypt(input logic [255:0] key, input logic [127:0] pt,
                                               input logic [1:0] size);
        int nk;
        int nr;
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [7:0]  s [16];
        logic [7:0]  u [16];
        logic [127:0] res;
        nk = (size == 2'd1) ? 6 : (size == 2'd2) ? 8 : 4;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t  = m_subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = m_mul(rc, 8'h02);
            end else if (nk == 8 && i % 8 == 4) begin
                t = m_subword(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127 - 8*b -: 8] ^ w[b / 4][31 - 8*(b % 4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int b = 0; b < 16; b++) u[b] = sb[s[(b % 4) + 4*(((b / 4) + (b % 4)) % 4)]];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) begin
                        s[4*c + k] = m_mul(u[4*c + k], 8'h02) ^ m_mul(u[4*c + (k + 1) % 4], 8'h03)
                                   ^ u[4*c + (k + 2) % 4] ^ u[4*c + (k + 3) % 4];
                    end
                end
            end else begin
                s = u;
            end
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b / 4][31 - 8*(b % 4) -: 8];
        end
        for (int b = 0; b < 16; b++) res[127 - 8*b -: 8] = s[b];
        return res;
    endfunction

    task automatic run_op(input logic [255:0] k, input logic [127:0] d, input logic [1:0] s,
                          input logic dc, output logic [127:0] res, output int cyc);
        @(negedge clk);
        key_i  = k;
        data_i = d;
        size_i = s;
        dec_i  = dc;
        load_i = 1'b1;
        @(posedge clk);
        #1;
        load_i = 1'b0;
        cyc = 0;
        while (busy_o && cyc < 200) begin
            cyc++;
            @(posedge clk);
            #1;
        end
        res = data_o;
    endtask

    initial begin
        logic [255:0] vkey [3];
        logic [127:0] vct [3];
        int           vcyc [3];
        logic [127:0] pt;
        logic [127:0] din;
        logic [127:0] res;
        logic [127:0] exp;
        logic [255:0] k;
        logic [1:0]   s;
        logic         dc;
        int           cyc;
        int           nk;

        pt      = 128'h00112233445566778899aabbccddeeff;
        vkey[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        vkey[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        vkey[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        vct[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        vct[1]  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        vct[2]  = 128'h8ea2b7ca516745bfeafc49904b496089;
        vcyc[0] = 51;
        vcyc[1] = 59;
        vcyc[2] = 67;

        build_sbox();
        rst_ni = 1'b0;
        load_i = 1'b0;
        key_i  = '0;
        data_i = '0;
        size_i = '0;
        dec_i  = 1'b0;
        #12;
        check_eq("reset_busy", 128'(busy_o), 128'd0);
        check_eq("reset_data", data_o, 128'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        run_op({pt, 128'h0}, pt, 2'd0, 1'b0, res, cyc);
        check_eq("enc128_a", res, 128'h62f679be2bf0d931641e039ca3401bb2);
        check_eq("busy128_a", 128'(cyc), 128'd51);

        for (int v = 0; v < 3; v++) begin
            run_op(vkey[v], pt, 2'(v), 1'b0, res, cyc);
            check_eq($sformatf("enc_fips%0d", v), res, vct[v]);
            check_eq($sformatf("busy_fips%0d", v), 128'(cyc), 128'(vcyc[v]));
        end

        for (int v = 0; v < 3; v++) begin
`ifdef AES_DEC_EN
            exp = pt;
`else
            exp = m_encrypt(vkey[v], vct[v], 2'(v));
`endif
            run_op(vkey[v], vct[v], 2'(v), 1'b1, res, cyc);
            check_eq($sformatf("dec_fips%0d", v), res, exp);
        end

        // Load while busy must be ignored; data_o holds the previous result meanwhile.
        @(negedge clk);
        key_i  = vkey[0];
        data_i = pt;
        size_i = 2'd0;
        dec_i  = 1'b0;
        load_i = 1'b1;
        @(posedge clk);
        #1;
        load_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        key_i  = ~key_i;
        data_i = ~data_i;
        size_i = 2'd2;
        dec_i  = 1'b1;
        load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("hold_mid", data_o, exp);
        check_eq("busy_mid", 128'(busy_o), 128'd1);
        cyc = 0;
        while (busy_o && cyc < 200) begin
            cyc++;
            @(posedge clk);
            #1;
        end
        check_eq("ignore_load", data_o, vct[0]);
        @(posedge clk);
        #1;
        check_eq("idle_after", 128'(busy_o), 128'd0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        key_i  = vkey[1];
        data_i = pt;
        size_i = 2'd1;
        load_i = 1'b1;
        @(posedge clk);
        #1;
        load_i = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        check_eq("rst_busy", 128'(busy_o), 128'd0);
        check_eq("rst_data", data_o, 128'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        run_op(vkey[2], pt, 2'd2, 1'b0, res, cyc);
        check_eq("after_rst", res, vct[2]);
        check_eq("after_rst_busy", 128'(cyc), 128'd67);

        for (int t = 0; t < 20; t++) begin
            k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            s  = 2'($urandom_range(0, 3));
            dc = 1'($urandom_range(0, 1));
            nk = (s == 2'd1) ? 6 : (s == 2'd2) ? 8 : 4;
            din = pt;
            exp = m_encrypt(k, pt, s);
`ifdef AES_DEC_EN
            if (dc) begin
                din = exp;
                exp = pt;
            end
`endif
            run_op(k, din, s, dc, res, cyc);
            check_eq($sformatf("rand%0d_data", t), res, exp);
            // Expansion words plus Nr+1 round cycles.
            check_eq($sformatf("rand%0d_busy", t), 128'(cyc),
                     128'((4*(nk + 7) - nk) + (nk + 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
